// File: rtl/vwriteback_pkg.sv
// Shared vector package: FSM state type, default geometry and the PC address.
// Imported by vwriteback and vregfile.
package vwriteback_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_e;

  localparam int LANES_DEFAULT = 5;
  localparam int DW_DEFAULT    = 32;
  localparam int AW_DEFAULT    = 4;

  // Register 15 is the PC and lives outside the register file.
  localparam int PC_ADDR = 15;

  function automatic logic [3:0] clamp_count(input logic [3:0] cnt, input int lanes);
    if (int'(cnt) > lanes) begin
      return 4'(lanes);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vwriteback.sv
// Vector writeback sequencer: drains one latched vector request into the register
// file, one lane per cycle. Optional macro VWRITEBACK_BOUNDS_CHECK_EN rejects spans past r14.
module vwriteback
  import vwriteback_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         base_wa,
  input  logic [3:0]            count,
  input  logic [LANES*DW-1:0]   vdata,
  output logic                  we3,
  output logic [AW-1:0]         wa3,
  output logic [DW-1:0]         wd3,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW = AW + 5;
  localparam logic [AW-1:0] PC_WA = AW'(PC_ADDR);

  wb_state_e            state_reg;
  wb_state_e            state_next;
  logic [IW-1:0]        idx_reg;
  logic [3:0]           cnt_reg;
  logic [AW-1:0]        base_reg;
  logic [LANES*DW-1:0]  data_reg;
  logic                 done_reg;

  logic                 accept;
  logic                 reject;
  logic                 last_lane;
  logic [3:0]           cnt_clamped;
  logic [AW-1:0]        wa_cur;
  logic [DW-1:0]        lane_arr [LANES];

  assign accept      = (state_reg == IDLE) && in_valid;
  assign cnt_clamped = clamp_count(count, LANES);
  assign last_lane   = (4'(idx_reg) == (cnt_reg - 4'd1));

`ifdef VWRITEBACK_BOUNDS_CHECK_EN
  // base + c - 1 > 14 is the same as base + c > 15; widened so nothing wraps.
  logic [SW-1:0] span_end;
  logic          err_reg;

  assign span_end = SW'(base_wa) + SW'(cnt_clamped);
  assign reject   = (cnt_clamped != 4'd0) && (span_end > SW'(PC_ADDR));

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && reject;
    end
  end

  assign err = err_reg;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && (cnt_clamped != 4'd0) && !reject) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (last_lane) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, lane index and the registered completion pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_reg  <= '0;
      cnt_reg  <= '0;
      base_reg <= '0;
      data_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            base_reg <= base_wa;
            cnt_reg  <= cnt_clamped;
            data_reg <= vdata;
            idx_reg  <= '0;
            done_reg <= (cnt_clamped == 4'd0);
          end
        end
        WRITE: begin
          if (last_lane) begin
            done_reg <= 1'b1;
            idx_reg  <= '0;
          end else begin
            idx_reg  <= idx_reg + IW'(1);
          end
        end
        default: begin
          idx_reg <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_arr[gi] = data_reg[gi*DW +: DW];
  end

  assign wa_cur = base_reg + AW'(idx_reg);

  // Output logic: a write slot aimed at the PC keeps its cycle but is not issued.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
      end
      WRITE: begin
        busy = 1'b1;
        if (wa_cur != PC_WA) begin
          we3 = 1'b1;
          wa3 = wa_cur;
          wd3 = lane_arr[idx_reg];
        end
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign done = done_reg;

endmodule

// File: doc/vwriteback.md
VWRITEBACK -- requirements
Module: vwriteback

Interface
REQ-001 SHALL have parameter LANES, default 5: maximum vector lanes per request.
REQ-002 SHALL have parameter DW, default 32: data width per lane.
REQ-003 SHALL have parameter AW, default 4: register address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: vector writeback request present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-008 SHALL have port base_wa, input, AW bits: destination register of lane 0.
REQ-009 SHALL have port count, input, 4 bits: lanes to write, 0..15.
REQ-010 SHALL have port vdata, input, LANES*DW bits: lane i at bits [i*DW +: DW].
REQ-011 SHALL have port we3, output, 1 bit: register-file write enable.
REQ-012 SHALL have port wa3, output, AW bits: register-file write address.
REQ-013 SHALL have port wd3, output, DW bits: register-file write data.
REQ-014 SHALL have port busy, output, 1 bit: sequence in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse, request rejected (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE and WRITE; in_ready=1 only in IDLE; busy=1 only in WRITE.
REQ-018 SHALL accept a request when in_valid & in_ready in cycle N, latching base_wa, count and vdata; later input changes SHALL have no effect.
REQ-019 SHALL clamp a latched count greater than LANES to LANES.
REQ-020 SHALL, for count c≥1, enter WRITE and issue exactly one write per cycle in cycles N+1..N+c, with we3=1, wa3=(base+i) mod 2^AW, wd3=lane i, i=0..c-1.
REQ-021 SHALL return to IDLE after the write with i=c-1, with in_ready=1 in cycle N+c+1.
REQ-022 SHALL, for count=0, stay in IDLE, perform no write and pulse done in cycle N+1.
REQ-023 SHALL drive a registered done pulse for exactly one cycle, cycle N+c+1.
REQ-024 SHALL hold we3=0 whenever no write is issued; wa3 and wd3 SHALL be 0 when we3=0.
REQ-025 SHALL ignore in_valid while in WRITE, with no queuing.
REQ-026 SHALL suppress a write to address 15 (PC; not in register file): we3=0 that cycle, sequence timing unchanged.

Reset
REQ-027 SHALL, while reset=0 at a clock edge, go to IDLE, clear the lane index and latched request, and drive we3=0, wa3=0, wd3=0, busy=0, done=0, err=0, in_ready=1 on the next cycle.
REQ-028 SHALL abort a sequence on reset mid-WRITE: no further writes, and no done pulse for it.

Configuration
REQ-029 SHALL honour macro VWRITEBACK_BOUNDS_CHECK_EN as the only compile-time option.
REQ-030 SHALL, with VWRITEBACK_BOUNDS_CHECK_EN defined, reject an accepted request with base+c-1 > 14 (c≥1): no writes, stay IDLE, err=1 and done=0 in cycle N+1.
REQ-031 SHALL, without VWRITEBACK_BOUNDS_CHECK_EN, accept such requests, wrap addresses per REQ-020, suppress address 15 per REQ-026, and tie err to 0.

Structure
REQ-032 SHALL take the FSM state enum, LANES default, DW/AW defaults and the PC address constant 15 from the shared vector package, also used by vregfile.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 SHALL cover: base=2, count=3, lanes=A0,A1,A2 at N -> writes (2,A0),(3,A1),(4,A2) in N+1..N+3; done and in_ready at N+4.
REQ-035 SHALL cover: count=9, base=0 -> clamped to 5 writes at addresses 0..4; done at N+6.
REQ-036 SHALL cover: count=0 -> no write; done at N+1.
REQ-037 SHALL cover: base=13, count=3 -> with macro: err at N+1 and no writes; without macro: writes at 13 and 14, cycle N+3 we3=0 (address 15), address-0 write in N+4 is absent because c=3, done at N+4.
REQ-038 SHALL cover: reset=0 in cycle N+2 of a 5-lane sequence -> no writes after N+2, no done, in_ready=1 after reset release.
REQ-039 SHALL cover: in_valid held high during WRITE with different data -> ignored; next request accepted only when in_ready=1.
